// File: rtl/lcd_btn_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and default timing constants for the LCD
//                front-panel input conditioning block (lcd_btn_cond).
//                - ch_state_t : per-channel debounce FSM state encoding
//                - c_*        : default timing at a 100 MHz system clock
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Per-channel debounce state; 2-bit encoding.
    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } ch_state_t;

    // 10 ms debounce window at 100 MHz.
    localparam int c_DEBOUNCE_CYCLES = 1000000;
    // 500 ms hold before the first auto-repeat pulse.
    localparam int c_REPEAT_DELAY    = 50000000;
    // 100 ms between subsequent auto-repeat pulses.
    localparam int c_REPEAT_PERIOD   = 10000000;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_btn_cond_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_btn_cond_if
//  Description : Front-panel signal bundle between the board inputs and the
//                LCD controller.
//                  btn_raw   [N_BTN] raw push-buttons (1 = pressed)
//                  sw_raw            raw slide switch
//                  btn_level [N_BTN] debounced button levels
//                  btn_pulse [N_BTN] one-cycle press strobes
//                  sw_level          debounced switch level
//                modport master : source of raw inputs, sink of clean outputs
//                modport slave  : the conditioning block itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_btn_cond_if #(
    parameter int N_BTN = 4
);

    logic [N_BTN-1:0] btn_raw;
    logic             sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             sw_level;

    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_pulse,
        input  sw_level
    );

    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_pulse,
        output sw_level
    );

endinterface : lcd_btn_cond_if
`default_nettype wire

// File: rtl/lcd_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_debounce_ch
//  Description : One debounced input channel: two-flop synchroniser, 4-state
//                debounce FSM with saturating qualification counter, and a
//                registered one-cycle press pulse.
//                Optional macro LCD_BTN_REPEAT_EN adds an auto-repeat hold
//                counter (only on channels with PULSE_EN=1).
//  Ports       : clk     - system clock (rising edge)
//                rst     - synchronous active-high reset
//                raw_i   - asynchronous raw input
//                level_o - debounced level
//                pulse_o - one-cycle press strobe (0 when PULSE_EN=0)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_debounce_ch
    import lcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
`ifdef LCD_BTN_REPEAT_EN
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD,
`endif
    parameter bit PULSE_EN        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser; only sync2_q feeds the FSM.
    logic sync1_q;
    logic sync2_q;

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    logic press_evt;   // debounced press accepted this cycle
    logic rep_fire;    // auto-repeat strobe this cycle

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_evt = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                level_d = 1'b0;
                if (sync2_q) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end

            ST_PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = ST_PRESSED;
                    level_d   = 1'b1;
                    press_evt = 1'b1;
                end else begin
                    // Increment only below CNT_LAST, so the count saturates.
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PRESSED: begin
                level_d = 1'b1;
                if (!sync2_q) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = '0;
                end
            end

            ST_RELEASE_CHK: begin
                if (sync2_q) begin
                    // Glitch during release: back to PRESSED, no new pulse.
                    state_d = ST_PRESSED;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_RELEASED;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

        pulse_d = PULSE_EN & (press_evt | rep_fire);
    end

    // ------------------------------------------------------------------
    // Optional auto-repeat
    // ------------------------------------------------------------------
`ifdef LCD_BTN_REPEAT_EN
    if (PULSE_EN) begin : g_repeat
        localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                 : REPEAT_PERIOD;
        localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
        localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
        localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              rep_q,  rep_d;   // first repeat already emitted
        logic              fire;

        // Hold counter runs only while the channel stays in PRESSED; any
        // exit (including a release glitch) restarts the delay phase.
        always_comb begin
            hold_d = '0;
            rep_d  = 1'b0;
            fire   = 1'b0;
            if (state_q == ST_PRESSED && sync2_q) begin
                if (hold_q == (rep_q ? PERIOD_LAST : DELAY_LAST)) begin
                    fire   = 1'b1;
                    hold_d = '0;
                    rep_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                    rep_d  = rep_q;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                hold_q <= hold_d;
                rep_q  <= rep_d;
            end
        end

        assign rep_fire = fire;
    end else begin : g_no_repeat
        assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule : lcd_debounce_ch
`default_nettype wire

// File: rtl/lcd_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_btn_cond
//  Description : Front-panel input conditioning for the LCD controller.
//                Synchronises, debounces and edge-detects N_BTN push-buttons
//                and one slide switch. Buttons give a level and a one-cycle
//                press pulse; the switch gives a level only.
//                Optional macro LCD_BTN_REPEAT_EN enables button auto-repeat.
//  Ports       : clk    - system clock (rising edge)
//                rst    - synchronous active-high reset
//                bus_if - lcd_btn_cond_if.slave
//                         (btn_raw, sw_raw in; btn_level, btn_pulse, sw_level out)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_btn_cond
    import lcd_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_btn_cond_if.slave        bus_if
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("lcd_btn_cond: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("lcd_btn_cond: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_BTN-1:0] btn_level_w;
    logic [N_BTN-1:0] btn_pulse_w;
    logic             sw_level_w;
    logic             sw_pulse_unused;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        lcd_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef LCD_BTN_REPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .PULSE_EN        (1'b1)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (bus_if.btn_raw[i]),
            .level_o (btn_level_w[i]),
            .pulse_o (btn_pulse_w[i])
        );
    end

    // Switch channel: level only, its pulse output is held at 0.
    lcd_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef LCD_BTN_REPEAT_EN
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
        .PULSE_EN        (1'b0)
    ) u_sw (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (bus_if.sw_raw),
        .level_o (sw_level_w),
        .pulse_o (sw_pulse_unused)
    );

    assign bus_if.btn_level = btn_level_w;
    assign bus_if.btn_pulse = btn_pulse_w;
    assign bus_if.sw_level  = sw_level_w;

endmodule : lcd_btn_cond
`default_nettype wire

// File: tb/tb_lcd_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_btn_cond
//  Description : Self-checking bench for lcd_btn_cond with DEBOUNCE_CYCLES=4,
//                REPEAT_DELAY=20, REPEAT_PERIOD=8. Each case fills a per-edge
//                stimulus table and pushes the expected outputs for every
//                edge into a scoreboard queue; the runner pops and compares
//                after each edge. Edge numbers count from the first edge
//                after reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_btn_cond;

    localparam int N_BTN = 4;
    localparam int DEB   = 4;
    localparam int RD    = 20;
    localparam int RP    = 8;
    localparam int MAX_E = 64;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] pls;
        logic       sw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_btn_cond_if #(.N_BTN(N_BTN)) bus_if ();

    lcd_btn_cond #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    exp_t       exp_q[$];
    logic [3:0] stim_btn [MAX_E];
    logic       stim_sw  [MAX_E];
    logic       stim_rst [MAX_E];

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {23'd0, bus_if.btn_level, bus_if.btn_pulse, bus_if.sw_level};
    endfunction

    task automatic clear_case();
        for (int e = 0; e < MAX_E; e++) begin
            stim_btn[e] = 4'b0000;
            stim_sw[e]  = 1'b0;
            stim_rst[e] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [3:0] lvl, input logic [3:0] pls,
                            input logic sw);
        exp_t x;
        x.lvl = lvl;
        x.pls = pls;
        x.sw  = sw;
        exp_q.push_back(x);
    endtask

    // Starts and ends at a falling edge.
    task automatic apply_reset(input string tag);
        bus_if.btn_raw = '0;
        bus_if.sw_raw  = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_reset"}, observed(), 32'd0);
        rst = 1'b0;
    endtask

    task automatic run_case(input string tag, input int n);
        exp_t x;
        for (int e = 0; e < n; e++) begin
            rst            = stim_rst[e];
            bus_if.btn_raw = stim_btn[e];
            bus_if.sw_raw  = stim_sw[e];
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_val($sformatf("%s_sb_empty@%0d", tag, e), 32'd1, 32'd0);
            end else begin
                x = exp_q.pop_front();
                check_val($sformatf("%s@%0d", tag, e), observed(), {23'd0, x});
            end
        end
        rst = 1'b0;
        if (exp_q.size() != 0)
            check_val({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus_if.btn_raw = '0;
        bus_if.sw_raw  = 1'b0;
        @(negedge clk);

        // Clean press on button 0 from edge 10: level at 16, pulse only at 16.
        apply_reset("clean");
        clear_case();
        for (int e = 0; e < 21; e++) begin
            if (e >= 10) stim_btn[e] = 4'b0001;
            push_exp((e >= 16) ? 4'b0001 : 4'b0000,
                     (e == 16) ? 4'b0001 : 4'b0000, 1'b0);
        end
        run_case("clean", 21);

        // Bounce on button 1: 1,0,1,0 at edges 16..19, held from 20 -> pulse at 26.
        apply_reset("bounce");
        clear_case();
        for (int e = 0; e < 31; e++) begin
            if (e == 16 || e == 18 || e >= 20) stim_btn[e] = 4'b0010;
            push_exp((e >= 26) ? 4'b0010 : 4'b0000,
                     (e == 26) ? 4'b0010 : 4'b0000, 1'b0);
        end
        run_case("bounce", 31);

        // Release glitch on button 2 (low at edges 10,11), then real release at 16.
        apply_reset("glitch");
        clear_case();
        for (int e = 0; e < 27; e++) begin
            if (e < 10 || (e >= 12 && e < 16)) stim_btn[e] = 4'b0100;
            push_exp((e >= 6 && e < 22) ? 4'b0100 : 4'b0000,
                     (e == 6) ? 4'b0100 : 4'b0000, 1'b0);
        end
        run_case("glitch", 27);

        // All buttons and the switch together from edge 5 -> outputs at 11.
        apply_reset("simul");
        clear_case();
        for (int e = 0; e < 15; e++) begin
            if (e >= 5) begin
                stim_btn[e] = 4'b1111;
                stim_sw[e]  = 1'b1;
            end
            push_exp((e >= 11) ? 4'b1111 : 4'b0000,
                     (e == 11) ? 4'b1111 : 4'b0000, (e >= 11));
        end
        run_case("simul", 15);

        // Button 3 held from edge 0, reset at edge 3 -> level/pulse at 10.
        apply_reset("midrst");
        clear_case();
        for (int e = 0; e < 14; e++) begin
            stim_btn[e] = 4'b1000;
            if (e == 3) stim_rst[e] = 1'b1;
            push_exp((e >= 10) ? 4'b1000 : 4'b0000,
                     (e == 10) ? 4'b1000 : 4'b0000, 1'b0);
        end
        run_case("midrst", 14);

        // Long hold on button 0 (edges 0..43), released at 44 -> level falls at 50.
        apply_reset("hold");
        clear_case();
        for (int e = 0; e < 57; e++) begin
            logic p;
            if (e < 44) stim_btn[e] = 4'b0001;
`ifdef LCD_BTN_REPEAT_EN
            p = (e == 6 || e == 26 || e == 34 || e == 42);
`else
            p = (e == 6);
`endif
            push_exp((e >= 6 && e < 50) ? 4'b0001 : 4'b0000,
                     {3'b000, p}, 1'b0);
        end
        run_case("hold", 57);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lcd_btn_cond
`default_nettype wire

// File: doc/lcd_btn_cond.md
Name: lcd_btn_cond

Overview:
Input conditioning stage directly upstream of the LCD controller. It synchronises, debounces and edge-detects the raw board buttons and switch. It delivers clean stable levels plus one-cycle press pulses, so the controller's command logic reacts exactly once per physical press. One instance serves all front-panel inputs.

Parameters:
N_BTN, 4, number of push-button channels.
DEBOUNCE_CYCLES, 1000000, cycles a new input value must hold before it is accepted (10 ms at 100 MHz); must be >= 2.
REPEAT_DELAY, 50000000, cycles of continuous hold before the first auto-repeat pulse (LCD_BTN_REPEAT_EN only).
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (LCD_BTN_REPEAT_EN only).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
btn_raw  in  N_BTN  asynchronous raw push-buttons; 1 = pressed.
sw_raw  in  1  asynchronous raw slide switch.
btn_level  out  N_BTN  debounced button levels.
btn_pulse  out  N_BTN  one-cycle press strobes.
sw_level  out  1  debounced switch level.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. No other clock or reset.
- Reset (rst=1 at an edge): all sync flops, counters, FSMs and outputs are cleared to 0. btn_level=0, btn_pulse=0, sw_level=0. Reset overrides any in-progress count.
- Synchroniser: two-flop chain per channel (s1 <= raw, s2 <= s1). All following logic uses s2 only.
- Per-channel FSM, 2-bit state, one instance per button and one for the switch:
  - RELEASED: level 0. s2=1 -> PRESS_CHK, count cleared.
  - PRESS_CHK: if s2=0, return to RELEASED. Otherwise count++. When count reaches DEBOUNCE_CYCLES-1 with s2=1 -> PRESSED, level<=1, pulse<=1 for exactly one cycle.
  - PRESSED: level 1. s2=0 -> RELEASE_CHK, count cleared.
  - RELEASE_CHK: if s2=1, return to PRESSED with no pulse. Otherwise count++. At DEBOUNCE_CYCLES-1 -> RELEASED, level<=0.
- Latency: raw held from edge k -> level changes at edge k+DEBOUNCE_CYCLES+2. Pulse is registered and coincides with the rising level for one cycle.
- Bounce: any single-cycle reversion during a CHK state aborts that state and restarts the count from 0 on the next qualifying sample.
- Counter width: $clog2(DEBOUNCE_CYCLES). The count saturates and never wraps.
- Channels are independent. Multiple btn_pulse bits may be high in the same cycle. The switch channel produces no pulse.
- Button held through reset release: it is treated as a new press. After the full latency, level rises and one pulse fires.
- btn_pulse never exceeds one cycle per press without the optional feature.

Optional Feature:
Macro LCD_BTN_REPEAT_EN.
- Defined: in PRESSED, a hold counter runs. At REPEAT_DELAY cycles of continuous hold, the channel emits one extra pulse. After that it emits one pulse every REPEAT_PERIOD cycles while still PRESSED. Leaving PRESSED, or reset, clears the hold counter. The switch channel never repeats.
- Undefined: no hold counter is synthesised and exactly one pulse is produced per accepted press.

Decomposition:
- Package lcd_pkg: channel FSM state enum (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK) and default timing constants (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD at 100 MHz).
- Sub-module lcd_debounce_ch: one channel containing synchroniser, FSM, counter and optional repeat logic. It has a PULSE_EN parameter. The top instantiates it N_BTN times with PULSE_EN=1 and once for sw_raw with PULSE_EN=0.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: btn_raw=4'b0001 from edge 10 and held -> btn_level[0]=1 at edge 16; btn_pulse=4'b0001 for exactly the cycle after edge 16, then 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 on successive edges, then held 1 from edge 20 -> no pulse before edge 26; a single pulse at edge 26.
- Release glitch: while btn_level[2]=1, btn_raw[2]=0 for 2 cycles then 1 -> btn_level[2] stays 1; no new pulse.
- Simultaneous: btn_raw 0000->1111 at edge 5 -> btn_pulse=4'b1111 in one cycle at edge 11; sw_raw 0->1 at edge 5 -> sw_level=1 at edge 11, no pulse port.
- Reset mid-count: btn_raw[3]=1 at edge 0, rst=1 at edge 3 for 1 cycle, btn still held -> all outputs 0 during reset; level and pulse appear at edge 4+4+2=10.
- LCD_BTN_REPEAT_EN: btn_raw[0] held from edge 0 -> pulses at edges 6, 26, 34, 42; release -> no further pulses. With the macro undefined -> only the edge-6 pulse.
